// File: rtl/mbisr_chain_pkg.sv
// mbisr_chain_pkg: shared constants and types for the BISR repair-chain driver.
//   DEF_WORD_W / DEF_CHAIN_LEN : default repair-register width and chain length
//   OP_CAPTURE / OP_SHIFT      : cmd_op encodings
//   state_t                    : controller FSM states
package mbisr_chain_pkg;
    localparam int DEF_WORD_W    = 26;
    localparam int DEF_CHAIN_LEN = 4;

    localparam logic OP_CAPTURE = 1'b0;
    localparam logic OP_SHIFT   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        LOAD,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/mbisr_word_serdes.sv
// mbisr_word_serdes: one-word serializer/deserializer for the repair chain.
//   CLK, RSTB  : clock, synchronous active-low reset
//   load       : capture load_data into the tx register and restart the bit count
//   shift_en   : advance one bit (tx LSB out, so into rx MSB)
//   load_data  : word to serialize, LSB first
//   so         : serial data returning from the chain
//   si         : serial data toward the chain (tx LSB)
//   rx_word    : word assembled including the bit being sampled this cycle
//   last_bit   : current shift is the final bit of the word
module mbisr_word_serdes
    import mbisr_chain_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] load_data,
    input  logic              so,
    output logic              si,
    output logic [WORD_W-1:0] rx_word,
    output logic              last_bit
);
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] tx_sreg;
    logic [WORD_W-1:0] rx_sreg;
    logic [CNT_W-1:0]  bit_cnt;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            tx_sreg <= '0;
            rx_sreg <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            tx_sreg <= load_data;
            bit_cnt <= '0;
        end else if (shift_en) begin
            tx_sreg <= tx_sreg >> 1;
            rx_sreg <= rx_word;
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    assign si       = tx_sreg[0];
    // The chain output is already valid at the sampling edge, so the final
    // word is available combinationally on its last shift cycle.
    assign rx_word  = {so, rx_sreg[WORD_W-1:1]};
    assign last_bit = (bit_cnt == CNT_W'(WORD_W - 1));
endmodule

// File: rtl/mbisr_chain_driver.sv
// mbisr_chain_driver: controller end of the memory BISR repair-register chain.
// Optional feature macro: MBISR_CHAIN_PARITY_EN adds unload_par, the XOR of all
// bits unloaded by the most recent SHIFT command.
//   CLK, RSTB            : clock, synchronous active-low reset
//   cmd_valid/op/ready   : command (0=CAPTURE, 1=SHIFT), accepted only in IDLE
//   in_valid/data/ready  : repair words to shift in, LSB first
//   out_valid/data/ready : 1-deep slot of unloaded words, LSB first
//   CHAIN_SI/SE/CKEN     : chain serial in, scan enable, clock enable
//   CHAIN_SO             : chain serial out
//   busy, done           : not IDLE; one-cycle completion pulse
//   unload_par           : (MBISR_CHAIN_PARITY_EN only) unload parity
module mbisr_chain_driver
    import mbisr_chain_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              cmd_valid,
    input  logic              cmd_op,
    output logic              cmd_ready,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              CHAIN_SI,
    output logic              CHAIN_SE,
    output logic              CHAIN_CKEN,
    input  logic              CHAIN_SO,
    output logic              busy,
    output logic              done
`ifdef MBISR_CHAIN_PARITY_EN
    ,
    output logic              unload_par
`endif
);
    localparam int WC_W = $clog2(CHAIN_LEN + 1);

    state_t            state, state_n;
    logic [WC_W-1:0]   word_cnt;
    logic              load, shift_en;
    logic              si, last_bit;
    logic [WORD_W-1:0] rx_word;
    logic              fill;

    mbisr_word_serdes #(.WORD_W(WORD_W)) u_serdes (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (in_data),
        .so        (CHAIN_SO),
        .si        (si),
        .rx_word   (rx_word),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_n    = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        CHAIN_CKEN = 1'b0;
        CHAIN_SE   = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    state_n = (cmd_op == OP_SHIFT) ? LOAD : CAPTURE;
            end
            CAPTURE: begin
                CHAIN_CKEN = 1'b1;
                CHAIN_SE   = 1'b0;
                state_n    = DONE;
            end
            LOAD: begin
                // Chain is frozen here; a word only starts once the slot can
                // take its unload, so a word never stalls mid-shift.
                if (in_valid && (!out_valid || out_ready)) begin
                    in_ready = 1'b1;
                    load     = 1'b1;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                CHAIN_CKEN = 1'b1;
                shift_en   = 1'b1;
                if (last_bit)
                    state_n = (word_cnt < WC_W'(CHAIN_LEN - 1)) ? LOAD : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign CHAIN_SI = shift_en & si;
    assign fill     = shift_en & last_bit;

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state     <= IDLE;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_n;
            if (fill)
                out_data <= rx_word;
            // Fill wins over drain: same-cycle fill+drain keeps the slot full.
            if (fill)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (state == DONE)
                word_cnt <= '0;
            else if (fill)
                word_cnt <= word_cnt + 1'b1;
        end
    end

`ifdef MBISR_CHAIN_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RSTB)
            unload_par <= 1'b0;
        else if (cmd_valid && cmd_ready && (cmd_op == OP_SHIFT))
            unload_par <= 1'b0;
        else if (shift_en)
            unload_par <= unload_par ^ CHAIN_SO;
    end
`endif
endmodule
